donut_phase_sched: RTL
======================

# donut_phase_sched

Time-division scheduler for the shared squarer bank in the donut VGA renderer. It divides each pixel into `NPH` clock phases and drives the `phase` select that switches squarer operands. It issues the pixel-advance enable to the hvsync generator and OR-accumulates the per-phase hit vectors into one registered per-pixel result. It also owns the per-frame animation counter that drives the square sprites.

## Interface

Parameters:

- `NPH`, default 2: phases per pixel, legal range 2..4.
- `PH_W`, default 2: width of the `phase` output; must satisfy `2**PH_W >= NPH`.
- `HIT_W`, default 8: width of the per-phase hit vector.
- `FC_W`, default 8: frame counter width.
- `FC_STEP`, default 8: frame counter increment per frame.

Ports:

- `clk` input 1: clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `run` input 1: scheduler enable; low freezes the scheduler (see Operation).
- `hit_in` input HIT_W: hit bits computed from the current phase's squarer outputs.
- `frame_top` input 1: high while vertical position == 0.
- `vsync_in` input 1: vsync from the hvsync generator.
- `phase` output PH_W: current phase index, used as the squarer operand select.
- `pix_en` output 1: one-cycle pulse on the last phase; the hvsync generator advances on it.
- `hit_out` output HIT_W: OR of `hit_in` over all phases of the previous pixel.
- `hit_valid` output 1: one-cycle pulse when `hit_out` updates.
- `fc` output FC_W: frame counter.

## Operation

- Phase counter `ph`:
  - when `run` = 1: 0→1→…→NPH-1→0.
  - when `run` = 0: `ph` is forced to 0 on the next edge.
  - `phase` = `ph` (registered).
- `pix_en` = `run && ph == NPH-1`, combinational from registered `ph`. Pixel coordinates therefore stay stable across all NPH phases of a pixel.
- Accumulator `acc` (HIT_W), updated only while `run` = 1:
  - `ph` == 0: `acc <= hit_in` (clear and load).
  - 0 < `ph` < NPH-1: `acc <= acc | hit_in`.
  - `ph` == NPH-1: `hit_out <= acc | hit_in`, `hit_valid <= 1`.
  - all other cycles: `hit_valid <= 0`.
- `run` deasserted mid-pixel:
  - the partial `acc` is discarded (cleared) and no `hit_valid` is issued for that pixel.
  - `hit_out` holds its last value.
- `run` reasserted: the schedule restarts at `ph` = 0 with a fresh load of `acc`.
- Frame counter state: `fc` plus a `fired` flag.
  - `frame_top && !fired`: `fc <= fc + FC_STEP` (wraps modulo `2**FC_W`), `fired <= 1`.
  - else if `vsync_in`: `fired <= 0`.
  - `frame_top` and `vsync_in` both high: `frame_top` wins.
  - The counter is independent of `run`.
- Reset values: `ph`, `acc`, `hit_out`, `hit_valid`, `fc`, `fired` all 0; `pix_en` = 0 (since `ph` = 0 and NPH ≥ 2).

## Timing

- Pixel period is exactly NPH clocks while `run` = 1, with one `pix_en` pulse per period.
- `hit_in` is sampled on every edge. The combinational hit logic has one full clock to settle after `phase` changes.
- Latency:
  - `hit_out`/`hit_valid` appear on the edge that ends phase NPH-1, i.e. one clock after `pix_en`.
  - The result is visible while `ph` = 0 of the next pixel.
  - The top level delays hsync/vsync/`video_active` by NPH cycles to align with `hit_out`.
- `fc` changes on exactly one edge per frame: the first cycle `frame_top` is seen after a `vsync_in` clear.

## Configuration

- Macro: `DONUT_SCHED_ANIM_EN`.
- Defined: frame counter logic as above.
- Undefined: the `fc` and `fired` registers are not built; `fc` is tied to 0, and `frame_top`/`vsync_in` are ignored.

## Test plan

- Reset, then `run`=1, NPH=2:
  - `phase` sequence 0,1,0,1.
  - `pix_en` high only when `phase`=1.
  - `hit_valid` pulses every 2nd clock.
- NPH=2, `hit_in`=8'h01 on phase 0 and 8'h80 on phase 1 → next cycle `hit_out`=8'h81 with `hit_valid`=1. The following pixel with `hit_in`=0 in both phases → `hit_out`=8'h00.
- NPH=3, `run` dropped on `ph`=1 with a non-zero `hit_in`:
  - `phase`=0 next cycle, no `hit_valid`, `hit_out` unchanged.
  - After re-enable the first result uses only the new pixel's phases.
- `frame_top` held high for 100 cycles → `fc` goes 0→8 exactly once. Pulse `vsync_in`, reassert `frame_top` → `fc`=16. 32 frames from reset → `fc` wraps to 0.
- `frame_top` and `vsync_in` high on the same cycle with `fired`=0 → `fc` increments and `fired`=1.
- Synchronous reset asserted mid-pixel and mid-frame → on the next edge all outputs are 0 and `phase`=0. With `DONUT_SCHED_ANIM_EN` undefined, `fc`=0 under all stimulus.

Source files
------------

// File: rtl/donut_phase_sched.sv
// Phase scheduler for the donut renderer's shared squarer bank: phase select, pixel-advance
// enable, per-pixel hit accumulation and the per-frame animation counter (DONUT_SCHED_ANIM_EN).
module donut_phase_sched #(
  parameter int NPH     = 2,
  parameter int PH_W    = 2,
  parameter int HIT_W   = 8,
  parameter int FC_W    = 8,
  parameter int FC_STEP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [HIT_W-1:0] hit_in,
  input  logic             frame_top,
  input  logic             vsync_in,
  output logic [PH_W-1:0]  phase,
  output logic             pix_en,
  output logic [HIT_W-1:0] hit_out,
  output logic             hit_valid,
  output logic [FC_W-1:0]  fc
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPH - 1);

  logic [PH_W-1:0]  ph;
  logic [HIT_W-1:0] acc;
  logic             ph_first;
  logic             ph_last;

  assign ph_first = (ph == '0);
  assign ph_last  = (ph == PH_LAST);

  // The hvsync generator advances on the last phase, so coordinates hold for the whole pixel.
  assign pix_en = run && ph_last;
  assign phase  = ph;

  // NOTE: reset is sampled on the clock edge only; rst_n is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ph        <= '0;
      acc       <= '0;
      hit_out   <= '0;
      hit_valid <= 1'b0;
    end else if (run) begin
      // NOTE: non-blocking updates let every branch read the pre-edge ph and acc.
      ph        <= ph_last ? '0 : ph + 1'b1;
      hit_valid <= ph_last;
      acc       <= ph_first ? hit_in : (acc | hit_in);
      if (ph_last) hit_out <= acc | hit_in;
    end else begin
      // Dropping run abandons the pixel in flight; hit_out keeps the last finished result.
      ph        <= '0;
      acc       <= '0;
      hit_valid <= 1'b0;
    end
  end

`ifdef DONUT_SCHED_ANIM_EN
  logic fired;

  // One increment per frame: fired blocks re-counting until vsync re-arms it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fc    <= '0;
      fired <= 1'b0;
    end else if (frame_top && !fired) begin
      fc    <= fc + FC_W'(FC_STEP);
      fired <= 1'b1;
    end else if (vsync_in) begin
      fired <= 1'b0;
    end
  end
`else
  logic unused_frame_inputs;

  assign fc                  = '0;
  assign unused_frame_inputs = frame_top ^ vsync_in;
`endif

endmodule
